// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional feature macro: LOAD_USE_STALL_EN. When it is undefined, the hazard
// detection and bubble counter are removed and the register only loads or flushes.
module id_ex_reg #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_reg_write,
   input  logic              id_mem2reg,
   input  logic              id_branch,
   input  logic              id_mem_write,
   input  logic              id_mem_read,
   input  logic              id_alu_src,
   input  logic              id_reg_dest,
   input  logic [1:0]        id_alu_op,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic              flush,
   output logic              ex_reg_write,
   output logic              ex_mem2reg,
   output logic              ex_branch,
   output logic              ex_mem_write,
   output logic              ex_mem_read,
   output logic              ex_alu_src,
   output logic              ex_reg_dest,
   output logic [1:0]        ex_alu_op,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [REG_W-1:0]  ex_rs,
   output logic [REG_W-1:0]  ex_rt,
   output logic [REG_W-1:0]  ex_rd,
   output logic              pc_write,
   output logic              if_id_write,
   output logic [15:0]       bubble_count
);

   // Control bundle layout: {reg_write, mem2reg, branch, mem_write, mem_read,
   // alu_src, reg_dest, alu_op[1:0]}
   localparam int unsigned CtrlW = 9;
   localparam int unsigned MemReadBit = 4;

   logic [CtrlW-1:0]  ctrl_d, ctrl_q;
   logic [DATA_W-1:0] rs_data_d, rs_data_q;
   logic [DATA_W-1:0] rt_data_d, rt_data_q;
   logic [DATA_W-1:0] imm_d, imm_q;
   logic [DATA_W-1:0] pc4_d, pc4_q;
   logic [REG_W-1:0]  rs_d, rs_q;
   logic [REG_W-1:0]  rt_d, rt_q;
   logic [REG_W-1:0]  rd_d, rd_q;
   logic              hazard;
   logic              stall;

`ifdef LOAD_USE_STALL_EN
   logic        uses_rt;
   logic [15:0] bubble_count_d, bubble_count_q;

   // Load in EX whose destination register is read by the instruction in ID
   always_comb begin
      uses_rt = ~id_alu_src | id_mem_write;
      hazard  = ctrl_q[MemReadBit] & (rt_q != '0)
              & ((rt_q == id_rs) | ((rt_q == id_rt) & uses_rt));
   end

   // Saturating bubble counter; flushes never count
   always_comb begin
      bubble_count_d = bubble_count_q;
      if (stall && (bubble_count_q != 16'hFFFF)) begin
         bubble_count_d = bubble_count_q + 16'd1;
      end
   end

   // Bubble counter state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_count_q <= '0;
      end else begin
         bubble_count_q <= bubble_count_d;
      end
   end

   assign bubble_count = bubble_count_q;
`else
   // Software schedules load delay slots; no interlock
   always_comb begin
      hazard = 1'b0;
   end

   assign bubble_count = '0;
`endif

   // Stall request and pipeline enables; a flush overrides the stall
   always_comb begin
      stall       = hazard & ~flush;
      pc_write    = ~stall;
      if_id_write = ~stall;
   end

   // Next entry: squash control on flush or bubble, scrub reg_dest when not writing
   always_comb begin
      ctrl_d = {id_reg_write, id_mem2reg, id_branch, id_mem_write, id_mem_read,
                id_alu_src, id_reg_dest & id_reg_write, id_alu_op};
      if (flush || stall) begin
         ctrl_d = '0;
      end
      rs_data_d = id_rs_data;
      rt_data_d = id_rt_data;
      imm_d     = id_imm;
      pc4_d     = id_pc4;
      rs_d      = id_rs;
      rt_d      = id_rt;
      rd_d      = id_rd;
   end

   // Pipeline register state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q    <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         pc4_q     <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         pc4_q     <= pc4_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
      end
   end

   assign {ex_reg_write, ex_mem2reg, ex_branch, ex_mem_write, ex_mem_read,
           ex_alu_src, ex_reg_dest, ex_alu_op} = ctrl_q;
   assign ex_rs_data = rs_data_q;
   assign ex_rt_data = rt_data_q;
   assign ex_imm     = imm_q;
   assign ex_pc4     = pc4_q;
   assign ex_rs      = rs_q;
   assign ex_rt      = rt_q;
   assign ex_rd      = rd_q;

endmodule
